// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified instruction/data memory port (CPU vs DMA/loader).
// Combinational grant, registered per-port read data, and a hold counter bounding consecutive wins.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  owner_t     owner, owner_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [3:0] hold_inc;
  logic       hold_ok;

  assign hold_ok  = (hold_cnt < HOLD_MAX);
  assign hold_inc = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 4'd1;

  // Grants are forced low while reset is high so an in-flight write never reaches the edge.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (cpu_req && dma_req) begin
        case (owner)
          OWN_CPU: begin
            cpu_gnt = hold_ok;
            dma_gnt = !hold_ok;
          end
          OWN_DMA: begin
            dma_gnt = hold_ok;
            cpu_gnt = !hold_ok;
          end
          default: cpu_gnt = 1'b1;
        endcase
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    owner_nxt = OWN_IDLE;
    hold_nxt  = 4'd0;
    if (cpu_gnt) begin
      owner_nxt = OWN_CPU;
      hold_nxt  = (owner == OWN_CPU) ? hold_inc : 4'd1;
    end else if (dma_gnt) begin
      owner_nxt = OWN_DMA;
      hold_nxt  = (owner == OWN_DMA) ? hold_inc : 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWN_IDLE;
      hold_cnt <= 4'd0;
    end else begin
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // rdata holds its last value between reads; rvalid marks the cycle after a granted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dma_rvalid <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MAX_HOLD=4 instance on a word memory model,
// plus a MAX_HOLD=1 instance for the strict-alternation case.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;

  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_cpu_req, b_dma_req;
  logic        b_cpu_gnt, b_dma_gnt, b_cpu_rvalid, b_dma_rvalid, b_mem_we;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(1)) dut_alt (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(32'h100), .cpu_wdata(32'h0),
    .cpu_gnt(b_cpu_gnt), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .dma_req(b_dma_req), .dma_we(1'b0), .dma_addr(32'h200), .dma_wdata(32'h0),
    .dma_gnt(b_dma_gnt), .dma_rdata(b_dma_rdata), .dma_rvalid(b_dma_rvalid),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Word memory with combinational read; out-of-window addresses read a marker value.
  assign mem_rdata = (mem_addr[31:10] == '0 && mem_addr[1:0] == 2'b00) ?
                     mem[mem_addr[9:2]] : 32'hBAD0_BAD0;
  assign b_mem_rdata = ~b_mem_addr;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (mem_we && mem_addr[31:10] == '0) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_c, prev_d, ec, ed;

    // Test 1: reset with both requesting
    reset = 1'b1; mem_init = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4; dma_wdata = 32'h0;
    b_cpu_req = 1'b0; b_dma_req = 1'b0;
    next_cycle();
    mem_init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
      check("rst_dma_gnt", 64'(dma_gnt), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'd0);
      check("rst_rdata", {cpu_rdata, dma_rdata}, 64'd0);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rel_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("rel_dma_gnt", 64'(dma_gnt), 64'd0);
    check("rel_mem_addr", 64'(mem_addr), 64'h0);
    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    check("rel_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("rel_cpu_rdata", 64'(cpu_rdata), 64'hA000_0000);

    // Test 2: DMA write then CPU read-back of the same word
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_dma_gnt", 64'(dma_gnt), 64'd1);
    check("wr_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("wr_mem_we", 64'(mem_we), 64'd1);
    check("wr_mem_addr", 64'(mem_addr), 64'h40);
    check("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    next_cycle();
    dma_req = 1'b0; dma_we = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h40;
    @(negedge clk);
    check("rb_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("rb_dma_rvalid", 64'(dma_rvalid), 64'd0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rb_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("rb_cpu_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    check("rb_dma_rvalid2", 64'(dma_rvalid), 64'd0);

    // Test 3: both reading continuously -> CPUx4, DMAx4, ...
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h8;
    dma_req = 1'b1; dma_addr = 32'hC;
    prev_c = 1'b0; prev_d = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ec = ((k / 4) % 2 == 0);
      ed = !ec;
      check($sformatf("fair_cpu_gnt[%0d]", k), 64'(cpu_gnt), 64'(ec));
      check($sformatf("fair_dma_gnt[%0d]", k), 64'(dma_gnt), 64'(ed));
      check($sformatf("fair_mem_addr[%0d]", k), 64'(mem_addr), ec ? 64'h8 : 64'hC);
      check($sformatf("fair_cpu_rvalid[%0d]", k), 64'(cpu_rvalid), 64'(prev_c));
      check($sformatf("fair_dma_rvalid[%0d]", k), 64'(dma_rvalid), 64'(prev_d));
      if (prev_c) check($sformatf("fair_cpu_rdata[%0d]", k), 64'(cpu_rdata), 64'hA000_0002);
      if (prev_d) check($sformatf("fair_dma_rdata[%0d]", k), 64'(dma_rdata), 64'hA000_0003);
      prev_c = ec; prev_d = ed;
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0;

    // Test 4: CPU alone saturates, DMA arrives and wins immediately
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("solo_cpu_gnt[%0d]", k), 64'(cpu_gnt), 64'd1);
      next_cycle();
    end
    dma_req = 1'b1; dma_addr = 32'h14;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ed = (k < 4);
      check($sformatf("sat_dma_gnt[%0d]", k), 64'(dma_gnt), 64'(ed));
      check($sformatf("sat_cpu_gnt[%0d]", k), 64'(cpu_gnt), 64'(!ed));
      check($sformatf("sat_mem_addr[%0d]", k), 64'(mem_addr), ed ? 64'h14 : 64'h10);
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0;

    // Test 5: MAX_HOLD=1 alternates strictly
    next_cycle();
    b_cpu_req = 1'b1; b_dma_req = 1'b1;
    prev_c = 1'b0; prev_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ec = (k % 2 == 0);
      check($sformatf("alt_cpu_gnt[%0d]", k), 64'(b_cpu_gnt), 64'(ec));
      check($sformatf("alt_dma_gnt[%0d]", k), 64'(b_dma_gnt), 64'(!ec));
      check($sformatf("alt_mem[%0d]", k), {31'd0, b_mem_we, b_mem_wdata}, 64'd0);
      check($sformatf("alt_mem_addr[%0d]", k), 64'(b_mem_addr), ec ? 64'h100 : 64'h200);
      check($sformatf("alt_rvalid[%0d]", k), 64'({b_cpu_rvalid, b_dma_rvalid}), 64'({prev_c, prev_d}));
      if (prev_c) check($sformatf("alt_cpu_rdata[%0d]", k), 64'(b_cpu_rdata), 64'hFFFF_FEFF);
      if (prev_d) check($sformatf("alt_dma_rdata[%0d]", k), 64'(b_dma_rdata), 64'hFFFF_FDFF);
      prev_c = ec; prev_d = !ec;
      next_cycle();
    end
    b_cpu_req = 1'b0; b_dma_req = 1'b0;

    // Test 6: async reset lands on a granted DMA write
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h1234_5678;
    @(negedge clk);
    check("ar_dma_gnt_pre", 64'(dma_gnt), 64'd1);
    check("ar_mem_we_pre", 64'(mem_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_dma_gnt_drop", 64'(dma_gnt), 64'd0);
    check("ar_mem_we_drop", 64'(mem_we), 64'd0);
    next_cycle();
    dma_req = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    check("ar_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'd0);
    check("ar_dma_rdata", 64'(dma_rdata), 64'd0);
    check("ar_mem_kept", 64'(mem[32]), 64'hA000_0020);
    next_cycle();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    dma_req = 1'b1; dma_addr = 32'h84;
    @(negedge clk);
    check("ar_cpu_gnt_post", 64'(cpu_gnt), 64'd1);
    check("ar_dma_gnt_post", 64'(dma_gnt), 64'd0);
    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    check("ar_cpu_rvalid_post", 64'(cpu_rvalid), 64'd1);
    check("ar_cpu_rdata_post", 64'(cpu_rdata), 64'hA000_0020);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters:
  - the multicycle CPU datapath (fetch and load/store);
  - a DMA/loader master used to preload programs and inspect memory.
- Sits between the requesters and the memory instance.
- Decides the grant combinationally each cycle, registers read data, and enforces bounded fairness with a hold counter.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_HOLD, 4, max consecutive grants to one requester while the other is requesting (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU requests an access this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access performed this cycle (combinational)
cpu_rdata  out  DATA_W  registered read data for CPU
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
dma_req  in  1  DMA requests an access this cycle
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA byte address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access performed this cycle (combinational)
dma_rdata  out  DATA_W  registered read data for DMA
dma_rvalid  out  1  one-cycle pulse: dma_rdata updated
mem_we  out  1  memory write enable (write occurs at the clock edge)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Registered state:
  - owner ∈ {IDLE, CPU, DMA}: the requester granted in the previous cycle.
  - hold_cnt (4 bits): consecutive grants to owner.
- Reset (async): owner=IDLE, hold_cnt=0, cpu_rdata=dma_rdata=0, cpu_rvalid=dma_rvalid=0. While reset is high, cpu_gnt=dma_gnt=0 and mem_we=0.
- Grant rule, evaluated combinationally each cycle:
  - no req: no grant;
  - exactly one req: grant it;
  - both, owner=IDLE: CPU;
  - both, owner=CPU: CPU if hold_cnt<MAX_HOLD, else DMA;
  - both, owner=DMA: DMA if hold_cnt<MAX_HOLD, else CPU.
- At most one gnt is high per cycle, and a gnt is never high without its req.
- Memory drive:
  - granted requester's we/addr/wdata go to mem_we/mem_addr/mem_wdata;
  - no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- State transitions at the clock edge:
  - grant to same owner: hold_cnt = min(hold_cnt+1, MAX_HOLD);
  - grant to the other requester, or from IDLE: owner=granted, hold_cnt=1;
  - no grant: owner=IDLE, hold_cnt=0.
- Saturation: a lone requester keeps winning with hold_cnt saturated. If the other requester then arrives, ownership switches in that same cycle.
- Read path:
  - granted read (we=0): mem_rdata is captured into that port's rdata at the edge, and rvalid is high for exactly the following cycle. Latency is 1 cycle from the grant.
  - Granted write or no grant for a port: that port's rvalid=0 next cycle and its rdata holds its last value.
  - Back-to-back reads by one port give consecutive rvalid pulses.
- Write path: the write commits at the edge of the grant cycle. A read of the same address in the next cycle, by either port, returns the new data.
- Requester contract:
  - a requester keeps req and its address, data and we stable until it sees gnt;
  - a deasserted req before grant is a legal cancel with no side effects.
- Reset mid-operation: an access granted in a cycle whose edge coincides with reset assertion is dropped. No write commits and no rvalid is produced.

Test Plan:
1. Reset high for 3 cycles, all reqs high -> gnts=0, mem_we=0, rvalids=0, rdata=0. Release -> CPU granted first cycle.
2. DMA writes 0xDEADBEEF @0x40 (dma_gnt=1, mem_we=1); next cycle CPU reads 0x40 -> cpu_gnt=1, following cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dma_rvalid=0.
3. Both request reads continuously for 20 cycles with MAX_HOLD=4 -> grant sequence CPU×4, DMA×4, CPU×4, …. No cycle has both gnts or neither, and rvalid pulses match grants shifted by 1 cycle.
4. CPU alone for 10 cycles (hold_cnt saturates at 4), then DMA raises req -> DMA granted in that same cycle, CPU stalls (cpu_gnt=0) with its addr held, and CPU resumes after 4 DMA grants if both keep requesting.
5. MAX_HOLD=1, both requesting -> strict alternation CPU, DMA, CPU, DMA, ….
6. Assert reset asynchronously mid-cycle during a granted DMA write of 0x12345678 @0x80 -> outputs drop immediately and the location keeps its old value. After release, owner=IDLE and a simultaneous request is granted to CPU.
